// File: rtl/mod_iter_unit.sv
// Multi-cycle unsigned remainder engine (restoring shift-subtract, one dividend bit per clock).
// Optional build macro MOD_FAST_EXIT_EN: finish in one edge when b==0 or a<b.
module mod_iter_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] result
);

   localparam logic [2:0] OP_MOD = 3'b111;

`ifdef MOD_FAST_EXIT_EN
   localparam bit FAST_EXIT = 1'b1;
`else
   localparam bit FAST_EXIT = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e             state_q;
   logic [WIDTH-1:0]   q_q;
   logic [WIDTH-1:0]   d_q;
   // Partial remainder stays below the divisor, so its top bit is always zero and is not stored.
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   result_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;
   logic               div_zero_q;

   logic [WIDTH:0]     t_d;
   logic [WIDTH-1:0]   r_d;
   logic               accept_d;
   logic               fast_d;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      t_d = {r_q, q_q[WIDTH-1]};
      r_d = t_d[WIDTH-1:0];
      if (t_d >= {1'b0, d_q}) begin
         r_d = t_d[WIDTH-1:0] - d_q;
      end
      accept_d = ready_q && start && (alu_op == OP_MOD);
      fast_d   = FAST_EXIT && ((b == '0) || (a < b));
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         q_q        <= '0;
         d_q        <= '0;
         r_q        <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         case (state_q)
            S_BUSY: begin
               r_q   <= r_d;
               q_q   <= q_q << 1;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  result_q <= r_d;
                  state_q  <= S_DONE;
                  busy_q   <= 1'b0;
                  ready_q  <= 1'b1;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               // IDLE and DONE both accept; DONE always falls back to IDLE otherwise.
               done_q <= 1'b0;
               if (accept_d) begin
                  q_q        <= a;
                  d_q        <= b;
                  r_q        <= '0;
                  cnt_q      <= CNT_W'(WIDTH);
                  div_zero_q <= (b == '0);
                  if (fast_d) begin
                     result_q <= a;
                     state_q  <= S_DONE;
                     done_q   <= 1'b1;
                  end else begin
                     state_q  <= S_BUSY;
                     busy_q   <= 1'b1;
                     ready_q  <= 1'b0;
                  end
               end else begin
                  state_q <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign ready    = ready_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign result   = result_q;

endmodule

// File: doc/mod_iter_unit.md
Name: mod_iter_unit

Overview:
- Multi-cycle unsigned remainder engine for the ALU. Produces the per-bit remainder result that the ALU result-select stage routes out when ALU op = 3'b111 (mod).
- Algorithm: restoring shift-subtract, one dividend bit per clock, so latency is bounded and fixed.
- Sits directly upstream of the result-select stage. The ALU control unit launches it with a start/done handshake.

Parameters:
- WIDTH, 32, operand and result width in bits (≥2).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  launch request; sampled only when ready=1.
- alu_op  input  3  ALU operation code; start accepted only when alu_op==3'b111.
- a  input  WIDTH  dividend, captured on accepted start.
- b  input  WIDTH  divisor, captured on accepted start.
- ready  output  1  high in IDLE and DONE; unit can accept start.
- busy  output  1  high in BUSY.
- done  output  1  one-cycle pulse; result valid.
- div_zero  output  1  captured b was 0; valid with done, held until next accept.
- result  output  WIDTH  a mod b; held until next accept.

Behaviour:
- Reset: when rst_n=0 at a clk edge, state→IDLE and all internal registers cleared. Outputs: ready=1, busy=0, done=0, div_zero=0, result=0. Reset overrides everything, including mid-BUSY; the in-flight operation is discarded with no done pulse.
- States: IDLE, BUSY, DONE.
- Accept condition: ready & start & (alu_op==3'b111). Accepted at edge E0:
  - Q←a, D←b, R←0 (WIDTH+1 bits), cnt←WIDTH, div_zero←(b==0). State→BUSY.
  - result is not cleared until the final bit is processed.
- BUSY, each edge:
  - T={R[WIDTH-1:0], Q[WIDTH-1]}; if T≥{1'b0,D} then R←T−D else R←T; Q←Q<<1; cnt←cnt−1.
  - When cnt==1 on this edge: result←final R[WIDTH-1:0], state→DONE.
- Latency: done high in the cycle after edge E0+WIDTH (WIDTH=32 → 32 edges after accept). No throughput penalty: a new start can be accepted in the DONE cycle.
- DONE: done=1 for exactly one cycle, then IDLE. Accept in DONE behaves as accept in IDLE: state→BUSY, and that cycle's done pulse is still presented.
- Start while busy: ignored, no effect on operands or state.
- Start with alu_op≠3'b111: ignored.
- b==0: the algorithm naturally yields R=a, so result=a and div_zero=1, with normal latency.
- Arithmetic is unsigned throughout. The comparison uses the WIDTH+1-bit T against zero-extended D, so no overflow for D ≥ 2^(WIDTH-1).
- The result register holds its value through IDLE. It changes only at the final BUSY edge or on reset.

Optional Feature:
- Macro: MOD_FAST_EXIT_EN.
- Defined: on accept, if b==0 or a<b, state goes directly to DONE at E0. result←a, div_zero←(b==0), done pulses in the cycle after E0 (1-edge latency). Other operands use full WIDTH-edge latency.
- Undefined: every accepted operation takes WIDTH edges, regardless of operands.

Test Plan:
- Basic remainder: rst_n=0 for 2 cycles, then a=100, b=7, start, alu_op=3'b111 → outputs hold reset values during reset. done pulses exactly 32 edges after accept, result=2, div_zero=0, busy=1 for 32 cycles.
- Large operands: a=0xFFFFFFFF, b=0x10 → result=0xF. Also a=0xFFFFFFFF, b=0x80000001 → result=0x7FFFFFFE.
- Divide by zero: a=5, b=0 → result=5, div_zero=1. Latency 32 edges without the macro, 1 edge with MOD_FAST_EXIT_EN.
- Small dividend and wrong-op filtering: a=3, b=10 → result=3 (32 edges, or 1 with the macro). start with alu_op=3'b101 → not accepted, ready stays 1, no done.
- Handshake ordering: start re-asserted with a=9, b=4 while busy → ignored, first result unchanged. Second start issued in the DONE cycle → accepted, next done 32 edges later with result=1.
- Reset mid-operation: rst_n=0 at edge 10 of BUSY → next cycle busy=0, ready=1, result=0, no done pulse.
